// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - execute-stage divider request/result bundle
// Groups the divide request, pipeline control and result signals of div_unit.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             advance;
   logic             stall_div;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;

   modport master (
      output start, signed_div, a, b, cancel, advance,
      input  stall_div, done, result_lo, result_hi
   );

   modport slave (
      input  start, signed_div, a, b, cancel, advance,
      output stall_div, done, result_lo, result_hi
   );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
// Optional DIV_EARLY_EXIT_EN: finish in one cycle when |a| < |b| and b != 0.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  dif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic             early;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             diff_hi;
   logic             neg;
   logic [WIDTH-1:0] quo_next, rem_next;

   always_comb begin
      mag_a = (dif.signed_div && dif.a[WIDTH-1]) ? -dif.a : dif.a;
      mag_b = (dif.signed_div && dif.b[WIDTH-1]) ? -dif.b : dif.b;
`ifdef DIV_EARLY_EXIT_EN
      early = (dif.b != '0) && (mag_a < mag_b);
`else
      early = 1'b0;
`endif
      shifted         = {rem_q, quo_q[WIDTH-1]};
      {diff_hi, diff} = shifted - {1'b0, dvs_q};
      // A set top bit of the shifted remainder already exceeds any divisor.
      neg      = ~shifted[WIDTH] & diff_hi;
      quo_next = {quo_q[WIDTH-2:0], ~neg};
      rem_next = neg ? shifted[WIDTH-1:0] : diff;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      done_d  = done_q;
      if (dif.cancel) begin
         state_d = IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dif.start) begin
                  if (dif.b == '0) begin
                     state_d = DONE;
                     lo_d    = '1;
                     hi_d    = dif.a;
                     done_d  = 1'b1;
                  end else if (early) begin
                     state_d = DONE;
                     lo_d    = '0;
                     hi_d    = dif.a;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                     rem_d   = '0;
                     quo_d   = mag_a;
                     dvs_d   = mag_b;
                     negq_d  = dif.signed_div & (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
                     negr_d  = dif.signed_div & dif.a[WIDTH-1];
                     cnt_d   = '0;
                  end
               end
            end
            RUN: begin
               rem_d = rem_next;
               quo_d = quo_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  lo_d    = negq_q ? -quo_next : quo_next;
                  hi_d    = negr_q ? -rem_next : rem_next;
               end
            end
            DONE: begin
               // Start is ignored here so the same E-stage instruction cannot restart.
               if (dif.advance) begin
                  state_d = IDLE;
                  done_d  = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         done_q  <= done_d;
      end
   end

   assign dif.stall_div = ((state_q == IDLE) && dif.start && !dif.cancel) || (state_q == RUN);
   assign dif.done      = done_q;
   assign dif.result_lo = lo_q;
   assign dif.result_hi = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
// Directed divides; a monitor compares each new done against a queue of expected results.
module tb_div_unit;
   localparam int W = 32;
`ifdef DIV_EARLY_EXIT_EN
   localparam int SMALL_DONE = 2;
`else
   localparam int SMALL_DONE = 34;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_unit_if #(.WIDTH(W)) dif ();

   div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .dif (dif.slave)
   );

   logic [63:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   logic done_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: compare results on the first cycle of every done window.
   always @(negedge clk) begin
      if (rst) begin
         done_prev = 1'b0;
      end else begin
         if (dif.done && !done_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", {dif.result_lo, dif.result_hi}, 64'hx);
            end else begin
               check("result_lo_hi", {dif.result_lo, dif.result_hi}, exp_q.pop_front());
            end
         end
         done_prev = dif.done;
      end
   end

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
   task automatic do_div(input string name, input logic sgn, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi, input int edone, input int hold);
      int n, done_at, stalls;
      exp_q.push_back({elo, ehi});
      dif.start      = 1'b1;
      dif.signed_div = sgn;
      dif.a          = av;
      dif.b          = bv;
      dif.advance    = 1'b1;
      n = 0; done_at = 0; stalls = 0;
      while (done_at == 0 && n < 100) begin
         @(negedge clk);
         n++;
         if (dif.done) begin
            done_at = n;
         end else begin
            if (dif.stall_div) stalls++;
            @(posedge clk);
            #1;
            if (n == 1) begin
               dif.a          = ~av;
               dif.b          = ~bv;
               dif.signed_div = ~sgn;
            end
         end
      end
      check({name, "_done_cycle"}, 64'(done_at), 64'(edone));
      check({name, "_stall_cycles"}, 64'(stalls), 64'(edone - 1));
      check({name, "_stall_in_done"}, 64'(dif.stall_div), 64'd0);
      if (hold > 0) begin
         dif.advance = 1'b0;
         for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            check({name, "_hold_done"}, 64'(dif.done), 64'd1);
            check({name, "_hold_stall"}, 64'(dif.stall_div), 64'd0);
            check({name, "_hold_results"}, {dif.result_lo, dif.result_hi}, {elo, ehi});
            if (k == hold) dif.advance = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int saw_done;
      rst            = 1'b1;
      dif.start      = 1'b0;
      dif.signed_div = 1'b0;
      dif.a          = '0;
      dif.b          = '0;
      dif.cancel     = 1'b0;
      dif.advance    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {60'd0, dif.done, dif.stall_div, |dif.result_lo, |dif.result_hi}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);
      do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
      do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 0);
      do_div("divu_by_zero", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 2, 0);
      do_div("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 0);

      // Cancel on RUN cycle 10 of DIV 100/7.
      dif.start = 1'b1; dif.signed_div = 1'b1; dif.a = 32'd100; dif.b = 32'd7;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      dif.cancel = 1'b1;
      dif.start  = 1'b0;
      @(posedge clk);
      #1;
      dif.cancel = 1'b0;
      @(negedge clk);
      check("cancel_stall", 64'(dif.stall_div), 64'd0);
      check("cancel_done", 64'(dif.done), 64'd0);
      check("cancel_results_held", {dif.result_lo, dif.result_hi}, {32'h8000_0000, 32'd0});
      saw_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif.done) saw_done = 1;
      end
      check("cancel_no_done", 64'(saw_done), 64'd0);
      @(posedge clk);
      #1;
      do_div("divu_9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 34, 0);

      do_div("divu_hold", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 3);
      do_div("divu_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 34, 0);
      do_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, SMALL_DONE, 0);
      do_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, SMALL_DONE, 0);

      // Reset in the middle of a divide.
      dif.start = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd1000; dif.b = 32'd3;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst       = 1'b1;
      dif.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midop_reset", {60'd0, dif.done, dif.stall_div, |dif.result_lo, |dif.result_hi}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_div("divu_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 0);
      dif.start = 1'b0;
      repeat (3) @(negedge clk);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
- Sits beside the ALU, downstream of the controller's decoded E-stage control (alucontrolE, hilowriteD pipelined to E).
- Produces quotient (LO) and remainder (HI) for the HI/LO register write.
- Raises a stall request to the hazard unit while iterating.

Parameters:
- WIDTH, 32, operand/result width (bits).
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  divide instruction valid in E (decoded from alucontrolE)
- signed_div  input  1  1 = DIV (signed), 0 = DIVU
- a  input  WIDTH  dividend (rs value, post-forwarding)
- b  input  WIDTH  divisor (rt value, post-forwarding)
- cancel  input  1  flushE; aborts any operation
- advance  input  1  ~stallE from hazard unit; pipeline moves E->M this cycle
- stall_div  output  1  stall request to hazard unit
- done  output  1  results valid this cycle
- result_lo  output  WIDTH  quotient
- result_hi  output  WIDTH  remainder

Behaviour:
- Reset: state IDLE; done=0; stall_div=0; result_lo=0; result_hi=0; counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 & cancel=0 latches |a|, |b|, sign_q = signed_div & (a[31]^b[31]), sign_r = signed_div & a[31].
  - Magnitudes are taken only when signed_div=1.
  - Clears the partial remainder, counter=0, then goes to RUN.
- RUN:
  - One quotient bit per cycle, MSB first.
  - Shift {rem,quo} left by 1; subtract divisor; restore if negative.
  - 33-bit subtraction width.
  - After WIDTH iterations (counter==WIDTH-1) go to DONE.
- DONE:
  - Registered results are applied: quotient negated if sign_q, remainder negated if sign_r.
  - result_lo/hi update on entry to DONE and hold until the next DONE.
  - done=1 throughout DONE.
  - advance=1 goes to IDLE; otherwise remain in DONE (start is ignored in DONE, so no restart while the instruction is still in E).
- stall_div (combinational): (state==IDLE & start & ~cancel) | state==RUN. Low in DONE.
- Latency: start cycle plus WIDTH RUN cycles stalled; done in cycle WIDTH+2 counting the start cycle as 1. For 32 bits that is 33 stall cycles, done on the 34th.
- Divide by zero (b==0): IDLE goes directly to DONE next cycle with result_lo=all-ones, result_hi=a (raw a, unmodified). stall_div is high only in the start cycle.
- Overflow 0x80000000 / 0xFFFFFFFF signed: result_lo=0x80000000, result_hi=0, no special state.
- cancel=1 in any state: next state IDLE, done=0 next cycle, results unchanged, counter cleared. cancel has priority over start and advance.
- rst mid-operation: identical to reset values next cycle.
- Back-to-back divides: DONE with advance=1 goes to IDLE. The next divide's start is sampled in IDLE the following cycle, with no result corruption.
- Operand inputs are ignored after the start cycle.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if b!=0 and |a| < |b| (unsigned magnitude compare), go directly to DONE with quotient=0, remainder=a (raw). stall_div is high only in the start cycle; done appears on cycle 2.
- Undefined: all nonzero divisors take the full WIDTH RUN cycles.

Test Plan:
- DIVU a=100, b=7, start held, advance=1 -> stall_div high 33 cycles, done on cycle 34, lo=14 (0x0E), hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIVU a=0x1234, b=0 -> done cycle 2, lo=0xFFFFFFFF, hi=0x1234, stall_div=1 for exactly 1 cycle.
- DIV a=100, b=7, cancel pulsed on RUN cycle 10 -> IDLE next cycle, stall_div=0, done never asserts, prior results held. Then DIVU 9/2 -> lo=4, hi=1.
- DIVU 100/7 with advance=0 for 3 cycles in DONE -> done held 4 cycles, start high throughout, no restart; lo/hi stable. Immediate second DIVU 50/5 -> lo=10, hi=0.
- With DIV_EARLY_EXIT_EN: DIVU 3/10 -> lo=0, hi=3, done cycle 2. Without it: same values, done cycle 34.
